// File: rtl/lsu_mem_arb.sv
// lsu_mem_arb: arbitrates one memory port between LSU load reads and a small
// write buffer of committed stores. At most one read outstanding, starvation
// protection for buffered stores, store-then-load ordering on address match.
// Optional build macro LSU_ARB_FWD_EN: forward matching store data to loads
// instead of draining the buffer before the read.
module lsu_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WB_DEPTH   = 4,
  parameter int WB_HI      = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_full,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rd_resp,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              err_overflow
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);
  localparam logic [CW-1:0] HI_C    = CW'(WB_HI);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     head, tail, idx;
  logic [CW-1:0]     count, count_nxt;
  logic [SW-1:0]     starve;
  logic              pend_rd, pend_wr;
  logic              sel_rd, sel_wr, addr_match;
  logic              deq, rd_acc, enq_ok, drop;
  logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
  logic [DATA_W-1:0] wb_data [WB_DEPTH];
`ifdef LSU_ARB_FWD_EN
  logic              sel_fwd;
  logic [DATA_W-1:0] fwd_data;
`endif

  // Saturating increment for the starve counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SMAX_C) ? v : v + 1'b1;
  endfunction

  // Compare the load address against every live buffer entry, oldest first,
  // so the last hit is the youngest matching store.
  always_comb begin
    addr_match = 1'b0;
    idx        = '0;
`ifdef LSU_ARB_FWD_EN
    fwd_data   = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (wb_addr[idx] == ld_req_addr)) begin
        addr_match = 1'b1;
`ifdef LSU_ARB_FWD_EN
        fwd_data   = wb_data[idx];
`endif
      end
    end
  end

  // Next-state and arbitration; a request left unaccepted is re-selected
  // so the memory port sees stable request fields.
  always_comb begin
    state_nxt = state;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
`ifdef LSU_ARB_FWD_EN
    sel_fwd   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pend_wr && (count != '0))
          sel_wr = 1'b1;
        else if (pend_rd && ld_req_valid)
          sel_rd = 1'b1;
        else if ((count != '0) && ((count >= HI_C) || (starve == SMAX_C)))
          sel_wr = 1'b1;
        else if (ld_req_valid && !addr_match)
          sel_rd = 1'b1;
        else if (ld_req_valid && addr_match)
`ifdef LSU_ARB_FWD_EN
          sel_fwd = 1'b1;
`else
          sel_wr = 1'b1;
`endif
        else if (count != '0)
          sel_wr = 1'b1;
        if (sel_rd && mem_req_ready)
          state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_resp)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request fields and handshake decode.
  always_comb begin
    mem_req_valid = sel_rd | sel_wr;
    mem_req_we    = sel_wr;
    mem_req_addr  = sel_wr ? wb_addr[head] : (sel_rd ? ld_req_addr : '0);
    mem_req_wdata = sel_wr ? wb_data[head] : '0;
`ifdef LSU_ARB_FWD_EN
    ld_req_ready  = (sel_rd & mem_req_ready) | sel_fwd;
`else
    ld_req_ready  = sel_rd & mem_req_ready;
`endif
    deq           = sel_wr & mem_req_ready;
    rd_acc        = sel_rd & mem_req_ready;
    enq_ok        = st_valid & ((count != DEPTH_C) | deq);
    drop          = st_valid & (count == DEPTH_C) & ~deq;
    count_nxt     = count + CW'(enq_ok) - CW'(deq);
  end

  // Write-buffer storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      wb_addr[tail] <= st_addr;
      wb_data[tail] <= st_data;
    end
  end

  // Control state: FSM, pointers, occupancy, starvation, load response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      starve        <= '0;
      pend_rd       <= 1'b0;
      pend_wr       <= 1'b0;
      st_full       <= 1'b0;
      err_overflow  <= 1'b0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      st_full <= (count_nxt == DEPTH_C);
      pend_rd <= sel_rd & ~mem_req_ready;
      pend_wr <= sel_wr & ~mem_req_ready;
      if (deq)    head <= head + 1'b1;
      if (enq_ok) tail <= tail + 1'b1;
      if (drop)   err_overflow <= 1'b1;
      if (deq || (count == '0))
        starve <= '0;
      else if (rd_acc)
        starve <= sat_inc(starve);
      ld_resp_valid <= 1'b0;
      if ((state == RD_WAIT) && mem_rd_resp) begin
        ld_resp_valid <= 1'b1;
        ld_resp_data  <= mem_rd_data;
      end
`ifdef LSU_ARB_FWD_EN
      if (sel_fwd) begin
        ld_resp_valid <= 1'b1;
        ld_resp_data  <= fwd_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_mem_arb.sv
// Directed bench for lsu_mem_arb: reset, single read, WB_HI/starvation
// ordering, store/load match (both build options), overflow, reset mid-read.
module tb_lsu_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [31:0] ld_req_addr = '0;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_full;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rd_resp = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic        err_overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        auto_rsp = 1'b0;
  logic [64:0] log_q [$];
  logic [64:0] exp_q [$];

  always #5 clk = ~clk;

  lsu_mem_arb dut (
    .clk(clk), .rst(rst),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_full(st_full),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rd_resp(mem_rd_resp), .mem_rd_data(mem_rd_data),
    .err_overflow(err_overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: log accepted requests at negedge, optionally answer a read
  // with a one-cycle response right after acceptance.
  task automatic tick();
    logic        rd_acc;
    logic [31:0] rd_addr;
    @(negedge clk);
    rd_acc  = mem_req_valid && mem_req_ready && !mem_req_we;
    rd_addr = mem_req_addr;
    if (mem_req_valid && mem_req_ready)
      log_q.push_back({mem_req_we, mem_req_addr, mem_req_wdata});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    if (auto_rsp) begin
      mem_rd_resp = rd_acc;
      mem_rd_data = rd_acc ? (32'hC0DE_0000 ^ rd_addr) : 32'h0;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    ld_req_valid = 1'b0; st_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rd_resp = 1'b0; auto_rsp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    log_q.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state and single read ----------------
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ld_req_ready", ld_req_ready, 0);
    check("rst_ld_resp_valid", ld_resp_valid, 0);
    check("rst_ld_resp_data", ld_resp_data, 0);
    check("rst_st_full", st_full, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_we", mem_req_we, 0);
    check("rst_err_overflow", err_overflow, 0);
    rst = 1'b1;
    mem_req_ready = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h100;
    #1;
    check("t1_req_valid", mem_req_valid, 1);
    check("t1_req_we", mem_req_we, 0);
    check("t1_req_addr", mem_req_addr, 32'h100);
    check("t1_ld_ready", ld_req_ready, 1);
    tick();
    ld_req_addr = 32'h104;
    #1;
    check("t1_wait1_req_valid", mem_req_valid, 0);
    check("t1_wait1_ld_ready", ld_req_ready, 0);
    tick();
    check("t1_wait2_req_valid", mem_req_valid, 0);
    check("t1_wait2_resp_valid", ld_resp_valid, 0);
    ld_req_valid = 1'b0;
    mem_rd_resp = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    tick();
    mem_rd_resp = 1'b0;
    #1;
    check("t1_resp_valid", ld_resp_valid, 1);
    check("t1_resp_data", ld_resp_data, 32'hDEAD_BEEF);
    check("t1_idle_no_req", mem_req_valid, 0);
    tick();
    check("t1_resp_pulse_end", ld_resp_valid, 0);
    check("t1_one_request", log_q.size(), 1);

    // ------- WB_HI priority, then starvation limit, FIFO order -------
    reset_dut();
    auto_rsp = 1'b1; mem_req_ready = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h200;
    store(32'h10, 32'h1010); tick();
    store(32'h14, 32'h1014); tick();
    store(32'h18, 32'h1018); tick();
    for (int t = 0; t < 200 && log_q.size() < 21; t++) tick();
    check("t2_log_len", log_q.size(), 21);
    ld_req_valid = 1'b0;
    exp_q.delete();
    repeat (2) exp_q.push_back({1'b0, 32'h200, 32'h0});
    exp_q.push_back({1'b1, 32'h10, 32'h1010});
    repeat (8) exp_q.push_back({1'b0, 32'h200, 32'h0});
    exp_q.push_back({1'b1, 32'h14, 32'h1014});
    repeat (8) exp_q.push_back({1'b0, 32'h200, 32'h0});
    exp_q.push_back({1'b1, 32'h18, 32'h1018});
    for (int i = 0; i < 21; i++)
      check($sformatf("t2_seq%0d", i), (i < log_q.size()) ? log_q[i] : 65'h0, exp_q[i]);
    tick(); tick();
    check("t2_st_full", st_full, 0);
    check("t2_no_overflow", err_overflow, 0);

    // ---------------- store then matching load ----------------
    reset_dut();
    auto_rsp = 1'b1; mem_req_ready = 1'b1;
    store(32'h40, 32'h55); tick();
    ld_req_valid = 1'b1; ld_req_addr = 32'h40;
    #1;
`ifdef LSU_ARB_FWD_EN
    check("t4_fwd_ready", ld_req_ready, 1);
    check("t4_fwd_no_mem", mem_req_valid, 0);
    tick();
    ld_req_valid = 1'b0;
    #1;
    check("t4_fwd_resp_valid", ld_resp_valid, 1);
    check("t4_fwd_resp_data", ld_resp_data, 32'h55);
    tick(); tick();
    check("t4_fwd_log_len", log_q.size(), 1);
    check("t4_fwd_write", log_q[0], {1'b1, 32'h40, 32'h55});
`else
    check("t4_wr_first_valid", mem_req_valid, 1);
    check("t4_wr_first_we", mem_req_we, 1);
    check("t4_wr_first_addr", mem_req_addr, 32'h40);
    check("t4_wr_first_data", mem_req_wdata, 32'h55);
    check("t4_ld_blocked", ld_req_ready, 0);
    tick();
    check("t4_rd_we", mem_req_we, 0);
    check("t4_rd_addr", mem_req_addr, 32'h40);
    check("t4_rd_ready", ld_req_ready, 1);
    tick();
    ld_req_valid = 1'b0;
    tick();
    check("t4_resp_valid", ld_resp_valid, 1);
    check("t4_resp_data", ld_resp_data, 32'hC0DE_0040);
    check("t4_log_len", log_q.size(), 2);
    check("t4_log_wr", log_q[0], {1'b1, 32'h40, 32'h55});
    check("t4_log_rd", log_q[1], {1'b0, 32'h40, 32'h0});
`endif

    // -------- overflow, full with simultaneous drain, held request --------
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      store(32'h80 + 32'(4 * i), 32'h2000 + 32'(i));
      if (i == 4) begin
        #1;
        check("t5_full", st_full, 1);
        check("t5_err_before", err_overflow, 0);
        check("t5_held_valid", mem_req_valid, 1);
        check("t5_held_addr", mem_req_addr, 32'h80);
      end
      tick();
    end
    check("t5_err_set", err_overflow, 1);
    check("t5_full_after_drop", st_full, 1);
    mem_req_ready = 1'b1;
    store(32'h94, 32'h2005);
    #1;
    check("t5_drain_head", mem_req_addr, 32'h80);
    tick();
    check("t5_full_enq_deq", st_full, 1);
    tick();
    check("t5_not_full", st_full, 0);
    repeat (4) tick();
    check("t5_log_len", log_q.size(), 5);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 32'h80 + 32'(4 * i), 32'h2000 + 32'(i)});
    exp_q.push_back({1'b1, 32'h94, 32'h2005});
    for (int i = 0; i < 5; i++)
      check($sformatf("t5_wr%0d", i), (i < log_q.size()) ? log_q[i] : 65'h0, exp_q[i]);
    check("t5_err_sticky", err_overflow, 1);
    check("t5_idle", mem_req_valid, 0);

    // ---------------- reset during outstanding read ----------------
    reset_dut();
    mem_req_ready = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h300;
    tick();
    ld_req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t6_in_reset_resp", ld_resp_valid, 0);
    tick();
    rst = 1'b1;
    mem_rd_resp = 1'b1; mem_rd_data = 32'h1234_5678;
    tick();
    mem_rd_resp = 1'b0;
    #1;
    check("t6_stale_resp", ld_resp_valid, 0);
    check("t6_stale_data", ld_resp_data, 0);
    ld_req_valid = 1'b1; ld_req_addr = 32'h304;
    #1;
    check("t6_idle_issue", mem_req_valid, 1);
    check("t6_idle_addr", mem_req_addr, 32'h304);
    ld_req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
